// File: rtl/skid_pkg.sv
// rtl/skid_pkg.sv - shared state encoding and depth constant for the skid stage
package skid_pkg;

   // Encoding doubles as the occupancy count driven on the level port
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_t;

   localparam int SKID_DEPTH = 2;

   // Occupancy implied by a state
   function automatic logic [1:0] st_level(input skid_state_t s);
      return 2'(s);
   endfunction

endpackage

// File: rtl/flopenr_n.sv
// rtl/flopenr_n.sv - enable flop with asynchronous active-low clear to zero
module flopenr_n #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Capture d when enabled; clear immediately on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/skid_pipe_stage.sv
// rtl/skid_pipe_stage.sv - two-entry elastic stage with fully registered outputs
module skid_pipe_stage
   import skid_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       level
);

   skid_state_t      st_q, st_d;
   logic             rst_done_q, rst_done_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [1:0]       level_q, level_d;
   logic             push, pop;
   logic             main_en, skid_en;
   logic [WIDTH-1:0] main_d, main_q, skid_q;

   // Next state and data-register enables; flush overrides every transition
   always_comb begin
      push    = in_valid & in_ready_q;
      pop     = out_valid_q & out_ready;
      st_d    = st_q;
      main_en = 1'b0;
      skid_en = 1'b0;
      main_d  = in_data;
      if (flush) begin
         st_d = ST_EMPTY;
      end else begin
         case (st_q)
            ST_EMPTY: begin
               if (push) begin
                  st_d    = ST_ONE;
                  main_en = 1'b1;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  main_en = 1'b1;
               end else if (push) begin
                  st_d    = ST_TWO;
                  skid_en = 1'b1;
               end else if (pop) begin
                  st_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  st_d    = ST_ONE;
                  main_en = 1'b1;
                  main_d  = skid_q;
               end
            end
            default: st_d = ST_EMPTY;
         endcase
      end
      // Handshake outputs are precomputed from the next state so they leave flops
      rst_done_d  = 1'b1;
      in_ready_d  = rst_done_d & (st_d != ST_TWO);
      out_valid_d = (st_d != ST_EMPTY);
      level_d     = st_level(st_d);
   end

   // State and registered handshake outputs; reset drops all held beats at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q        <= ST_EMPTY;
         rst_done_q  <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         level_q     <= 2'd0;
      end else begin
         st_q        <= st_d;
         rst_done_q  <= rst_done_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         level_q     <= level_d;
      end
   end

   flopenr_n #(.WIDTH(WIDTH)) u_main (
      .clk   (clk),
      .rst_n (reset),
      .en    (main_en),
      .d     (main_d),
      .q     (main_q)
   );

   flopenr_n #(.WIDTH(WIDTH)) u_skid (
      .clk   (clk),
      .rst_n (reset),
      .en    (skid_en),
      .d     (in_data),
      .q     (skid_q)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign level     = level_q;

endmodule

// File: tb/tb_skid_pipe_stage.sv
// tb/tb_skid_pipe_stage.sv - directed and random checks of skid_pipe_stage against a queue model
module tb_skid_pipe_stage;

   logic       clk;
   logic       reset;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] level;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   skid_pipe_stage #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: FIFO of held beats, capacity 2, plus the post-reset ready delay
   logic [7:0] mq[$];
   bit         m_rst_done;

   always @(posedge clk or negedge reset) begin
      bit m_ready, m_push, m_pop;
      if (!reset) begin
         mq.delete();
         m_rst_done = 0;
      end else begin
         m_ready = m_rst_done && (mq.size() < 2);
         m_push  = in_valid && m_ready;
         m_pop   = (mq.size() > 0) && out_ready;
         if (flush) begin
            mq.delete();
         end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(in_data);
         end
         m_rst_done = 1;
      end
   end

   // Per-cycle compare against the model, plus output stability under stall
   bit         pv, pr, pf, rst_seen;
   logic [7:0] pd;

   always @(negedge reset) rst_seen = 1;

   always @(negedge clk) begin
      chk("in_ready", {7'd0, in_ready}, {7'd0, m_rst_done && (mq.size() < 2)});
      chk("out_valid", {7'd0, out_valid}, {7'd0, mq.size() != 0});
      chk("level", {6'd0, level}, 8'(mq.size()));
      if (mq.size() != 0) chk("out_data", out_data, mq[0]);
      if (pv && !pr && !pf && !rst_seen) begin
         chk("stall_valid", {7'd0, out_valid}, 8'd1);
         chk("stall_data", out_data, pd);
      end
      pv = out_valid;
      pd = out_data;
      pr = out_ready;
      pf = flush;
      rst_seen = 0;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a beat and hold it until an edge accepts it (bounded)
   task automatic send(input logic [7:0] d);
      bit ok;
      ok = 0;
      in_valid = 1'b1;
      in_data  = d;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL send_timeout: beat %0h not accepted", d);
      end
   endtask

   int t0;

   initial begin
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h33;
      out_ready = 1'b0;

      // Reset held with in_valid asserted
      repeat (3) step();
      @(negedge clk);
      chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
      chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
      chk("rst_level", {6'd0, level}, 8'd0);
      chk("rst_out_data", out_data, 8'h00);
      step();
      reset    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rel_in_ready_early", {7'd0, in_ready}, 8'd0);
      @(negedge clk);
      chk("rel_in_ready", {7'd0, in_ready}, 8'd1);
      step();

      // Streaming at one beat per cycle
      out_ready = 1'b1;
      t0 = cyc;
      send(8'h01);
      in_valid = 1'b1;
      @(negedge clk);
      chk("stream_first", out_data, 8'h01);
      chk("stream_first_lvl", {6'd0, level}, 8'd1);
      step();
      t0 = cyc - 1;
      for (int i = 2; i <= 16; i++) send(8'(i));
      chk("stream_cycles", 8'(cyc - t0), 8'd16);
      @(negedge clk);
      chk("stream_last", out_data, 8'h10);
      in_valid = 1'b0;
      repeat (2) step();

      // Stall and skid
      out_ready = 1'b0;
      send(8'hA1);
      send(8'hA2);
      in_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("skid_level", {6'd0, level}, 8'd2);
         chk("skid_in_ready", {7'd0, in_ready}, 8'd0);
         chk("skid_head", out_data, 8'hA1);
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("drain_a1", out_data, 8'hA1);
      step();
      @(negedge clk);
      chk("drain_a2", out_data, 8'hA2);
      chk("drain_in_ready", {7'd0, in_ready}, 8'd1);
      step();
      @(negedge clk);
      chk("drain_empty", {7'd0, out_valid}, 8'd0);
      step();

      // Flush with a beat presented on the same edge
      out_ready = 1'b0;
      send(8'hB1);
      send(8'hB2);
      in_valid = 1'b1;
      in_data  = 8'h55;
      flush    = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_level", {6'd0, level}, 8'd0);
      chk("flush_valid", {7'd0, out_valid}, 8'd0);
      out_ready = 1'b1;
      repeat (4) step();

      // Reset pulse between edges while full
      out_ready = 1'b0;
      send(8'hC1);
      send(8'hC2);
      in_valid = 1'b0;
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", {7'd0, out_valid}, 8'd0);
      chk("mid_rst_level", {6'd0, level}, 8'd0);
      chk("mid_rst_ready", {7'd0, in_ready}, 8'd0);
      #1;
      reset = 1'b1;
      out_ready = 1'b1;
      send(8'h77);
      in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_data", out_data, 8'h77);
      chk("post_rst_level", {6'd0, level}, 8'd1);
      step();
      @(negedge clk);
      chk("post_rst_alone", {7'd0, out_valid}, 8'd0);
      step();

      // Random traffic against the model
      for (int i = 0; i < 10000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();
      @(negedge clk);
      chk("final_empty", {6'd0, level}, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
